// File: rtl/vote_session_ctrl.sv
// Ballot-session controller: qualifies candidate buttons and hands one vote per ballot to the counter bank.
// Optional build macro AUTO_ARM_EN: when defined, IDLE re-arms automatically and the arm port is ignored.
module vote_session_ctrl #(
    parameter int HOLD_CYCLES = 10,
    parameter int LOCK_CYCLES = 50,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode,
    input  logic             arm,
    input  logic             button1,
    input  logic             button2,
    input  logic             button3,
    input  logic             button4,
    input  logic             vote_ready,
    output logic             vote_valid,
    output logic [1:0]       vote_sel,
    output logic             armed,
    output logic             reject,
    output logic [CNT_W-1:0] ballots_cast
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        QUALIFY,
        ISSUE,
        RELEASE,
        COOLDOWN
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         meta_q, meta_d;
    logic [5:0]         sync_q, sync_d;
    logic [1:0]         sel_q, sel_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
    logic [CNT_W-1:0]   ballots_q, ballots_d;
    logic               reject_q, reject_d;

    logic               mode_s;
    logic               arm_s;
    logic [3:0]         btn_s;
    logic               btn_multi;
    logic               btn_single;
    logic [1:0]         btn_idx;
    logic [3:0]         sel_mask;
    logic               latched_hi;
    logic               others_hi;

    // Bit order {button4..button1, arm, mode}; every control decision uses the second stage.
    always_comb begin
        meta_d = {button4, button3, button2, button1, arm, mode};
        sync_d = meta_q;
    end

    assign mode_s = sync_q[0];
    assign arm_s  = sync_q[1];
    assign btn_s  = sync_q[5:2];

    assign btn_multi  = (btn_s & (btn_s - 4'd1)) != 4'd0;
    assign btn_single = (btn_s != 4'd0) && !btn_multi;
    assign sel_mask   = 4'b0001 << sel_q;
    assign latched_hi = (btn_s & sel_mask) != 4'd0;
    assign others_hi  = (btn_s & ~sel_mask) != 4'd0;

    always_comb begin
        btn_idx = 2'd0;
        case (btn_s)
            4'b0010: btn_idx = 2'd1;
            4'b0100: btn_idx = 2'd2;
            4'b1000: btn_idx = 2'd3;
            default: btn_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        lock_d    = lock_q;
        ballots_d = ballots_q;
        reject_d  = 1'b0;

        case (state_q)
            IDLE: begin
`ifdef AUTO_ARM_EN
                if (!mode_s) begin
                    state_d = ARMED;
                end
`else
                if (arm_s && !mode_s) begin
                    state_d = ARMED;
                end
`endif
            end

            ARMED: begin
                if (mode_s) begin
                    state_d = IDLE;
                end else if (btn_multi) begin
                    reject_d = 1'b1;
                    state_d  = RELEASE;
                end else if (btn_single) begin
                    sel_d   = btn_idx;
                    hold_d  = HOLD_W'(1);
                    // A single-cycle hold requirement is already met on first sight.
                    state_d = (HOLD_CYCLES == 1) ? ISSUE : QUALIFY;
                end
            end

            QUALIFY: begin
                if (mode_s) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (others_hi) begin
                    reject_d = 1'b1;
                    hold_d   = '0;
                    state_d  = RELEASE;
                end else if (latched_hi) begin
                    if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                        hold_d  = '0;
                        state_d = ISSUE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    hold_d  = '0;
                    state_d = ARMED;
                end
            end

            ISSUE: begin
                if (vote_ready) begin
                    if (ballots_q != {CNT_W{1'b1}}) begin
                        ballots_d = ballots_q + CNT_W'(1);
                    end
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (btn_s == 4'd0) begin
                    lock_d  = '0;
                    state_d = COOLDOWN;
                end
            end

            COOLDOWN: begin
                if (mode_s) begin
                    state_d = IDLE;
                end else if (lock_q == LOCK_W'(LOCK_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    lock_d = lock_q + LOCK_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            meta_q    <= '0;
            sync_q    <= '0;
            sel_q     <= '0;
            hold_q    <= '0;
            lock_q    <= '0;
            ballots_q <= '0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            lock_q    <= lock_d;
            ballots_q <= ballots_d;
            reject_q  <= reject_d;
        end
    end

    assign vote_valid   = (state_q == ISSUE);
    assign vote_sel     = sel_q;
    assign armed        = (state_q == ARMED) || (state_q == QUALIFY);
    assign reject       = reject_q;
    assign ballots_cast = ballots_q;

endmodule
